// File: rtl/ifetch.sv
// Instruction fetch unit: owns the PC, fetches one word per cycle from a
// combinational instruction memory and buffers {pc, inst} pairs for decode.
module ifetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] inst_addr,
  input  logic [31:0] inst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_inst,
  output logic        misalign
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } entry_t;

  entry_t             buf_mem [DEPTH];
  logic [31:0]        pc;
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;
  logic [CNT_W-1:0]   count;
  logic               full;
  logic               pop;
  logic               push;

  assign full      = (count == CNT_W'(DEPTH));
  assign out_valid = (count != '0);
  assign pop       = out_valid & out_ready;
  // A pop frees the slot the push needs, so full-and-draining never bubbles.
  assign push      = ~redirect_valid & (~full | pop);

  assign inst_addr = pc;
  assign out_pc    = buf_mem[rd_ptr].pc;
  assign out_inst  = buf_mem[rd_ptr].inst;

  // PC, pointers, occupancy and misalign flag; redirect overrides everything.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc       <= RESET_PC;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      misalign <= 1'b0;
    end else begin
      misalign <= redirect_valid & (redirect_pc[1:0] != 2'b00);
      if (redirect_valid) begin
        pc     <= {redirect_pc[31:2], 2'b00};
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) begin
          pc     <= pc + 32'd4;
          wr_ptr <= wr_ptr + PTR_W'(1);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + PTR_W'(1);
        end
        if (push && !pop) begin
          count <= count + CNT_W'(1);
        end else if (pop && !push) begin
          count <= count - CNT_W'(1);
        end
      end
    end
  end

  // Fetch buffer storage; cleared on reset so the idle head reads as zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        buf_mem[i] <= '0;
      end
    end else if (push) begin
      buf_mem[wr_ptr] <= '{pc: pc, inst: inst};
    end
  end

endmodule

// File: tb/tb_ifetch.sv
// Scoreboard bench for ifetch: a queue-based fetch model predicts per-cycle
// outputs and the accepted instruction stream; a monitor compares the DUT.
module tb_ifetch;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int unsigned DEPTH    = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] inst_addr;
  logic [31:0] inst;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic        misalign;

  ifetch #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .inst_addr(inst_addr), .inst(inst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_inst(out_inst), .misalign(misalign)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0:   return 32'h0000_0013;
      32'h4:   return 32'h0010_0093;
      32'h8:   return 32'h0020_0113;
      default: return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endcase
  endfunction

  assign inst = mem_word(inst_addr);

  typedef struct {
    logic [31:0] pc;
    logic [31:0] word;
  } ent_t;

  typedef struct {
    logic        valid;
    logic        mis;
    logic [31:0] addr;
    logic [31:0] hpc;
    logic [31:0] hinst;
  } rec_t;

  ent_t        m_q[$];
  logic [31:0] m_pc;
  logic        m_mis;
  rec_t        cyc_q[$];
  ent_t        acc_q[$];
  int          passed = 0;
  int          total = 0;
  bit          done = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_q.delete();
    m_pc  = RESET_PC;
    m_mis = 1'b0;
  endtask

  // One cycle: drive inputs, record expected outputs, advance the model.
  task automatic cycle(input logic r, input logic rv, input logic [31:0] rpc, input logic rdy);
    rec_t e;
    ent_t n;
    @(negedge clk);
    rst = r; redirect_valid = rv; redirect_pc = rpc; out_ready = rdy;
    if (r) model_reset();
    e.valid = (m_q.size() != 0);
    e.mis   = m_mis;
    e.addr  = m_pc;
    e.hpc   = e.valid ? m_q[0].pc : 32'h0;
    e.hinst = e.valid ? m_q[0].word : 32'h0;
    cyc_q.push_back(e);
    if (!r) begin
      if (rdy && m_q.size() != 0) acc_q.push_back(m_q.pop_front());
      m_mis = rv && (rpc[1:0] != 2'b00);
      if (rv) begin
        m_q.delete();
        m_pc = {rpc[31:2], 2'b00};
      end else if (m_q.size() < DEPTH) begin
        n.pc = m_pc;
        n.word = mem_word(m_pc);
        m_q.push_back(n);
        m_pc = m_pc + 32'd4;
      end
    end
  endtask

  // Reset raised between edges with the buffer held full.
  task automatic mid_reset();
    cycle(0, 0, 32'h0, 0);
    #5 rst = 1'b1;
    #1;
    chk("midrst_valid", 32'(out_valid), 32'h0);
    chk("midrst_pc", out_pc, 32'h0);
    chk("midrst_inst", out_inst, 32'h0);
    chk("midrst_addr", inst_addr, RESET_PC);
    model_reset();
    cycle(1, 0, 32'h0, 0);
    cycle(1, 0, 32'h0, 0);
  endtask

  // Monitor: per-cycle output check plus accepted-stream scoreboard.
  initial begin
    rec_t e;
    ent_t a;
    forever begin
      @(negedge clk);
      #2;
      if (!done) begin
        if (cyc_q.size() == 0) begin
          total++;
          $display("FAIL cyc_underflow: got empty expectation queue at %0t", $time);
        end else begin
          e = cyc_q.pop_front();
          chk("out_valid", 32'(out_valid), 32'(e.valid));
          chk("inst_addr", inst_addr, e.addr);
          chk("misalign", 32'(misalign), 32'(e.mis));
          if (e.valid) begin
            chk("head_pc", out_pc, e.hpc);
            chk("head_inst", out_inst, e.hinst);
          end
        end
        if (out_valid && out_ready) begin
          if (acc_q.size() == 0) begin
            total++;
            $display("FAIL acc_underflow: got handshake pc %h, none expected at %0t", out_pc, $time);
          end else begin
            a = acc_q.pop_front();
            chk("acc_pc", out_pc, a.pc);
            chk("acc_inst", out_inst, a.word);
          end
        end
      end
    end
  end

  initial begin
    logic [31:0] tgt;
    model_reset();
    // Reset and streaming
    cycle(1, 0, 32'h0, 1);
    cycle(1, 0, 32'h0, 1);
    repeat (6) cycle(0, 0, 32'h0, 1);
    // Backpressure from reset
    cycle(1, 0, 32'h0, 0);
    repeat (5) cycle(0, 0, 32'h0, 0);
    repeat (6) cycle(0, 0, 32'h0, 1);
    // Redirect with full buffer
    cycle(1, 0, 32'h0, 0);
    repeat (3) cycle(0, 0, 32'h0, 0);
    cycle(0, 1, 32'h100, 1);
    repeat (4) cycle(0, 0, 32'h0, 1);
    // Misaligned redirect
    cycle(0, 1, 32'h203, 1);
    repeat (4) cycle(0, 0, 32'h0, 1);
    // Back-to-back redirects
    cycle(0, 1, 32'h400, 1);
    cycle(0, 1, 32'h405, 0);
    cycle(0, 1, 32'h808, 1);
    repeat (3) cycle(0, 0, 32'h0, 1);
    // Wrap-around
    cycle(0, 1, 32'hFFFF_FFF8, 1);
    repeat (5) cycle(0, 0, 32'h0, 1);
    // Mid-stream reset while full
    repeat (3) cycle(0, 0, 32'h0, 0);
    mid_reset();
    repeat (4) cycle(0, 0, 32'h0, 1);
    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        mid_reset();
      end else if ($urandom_range(0, 9) == 0) begin
        case ($urandom_range(0, 3))
          0: tgt = $urandom & 32'hFFFF_FFFC;
          1: tgt = $urandom;
          2: tgt = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
          default: tgt = 32'($urandom_range(0, 255));
        endcase
        cycle(0, 1, tgt, 1'($urandom_range(0, 1)));
      end else begin
        cycle(0, 0, 32'h0, 1'($urandom_range(0, 9) < 7));
      end
    end
    #5;
    done = 1;
    chk("cyc_q_drained", 32'(cyc_q.size()), 32'h0);
    chk("acc_q_drained", 32'(acc_q.size()), 32'h0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/ifetch.md
# ifetch

Instruction fetch unit for the rvcore pipeline: the initiator side of the byte-addressed instruction memory port. It holds the program counter and drives a word address to the combinational instruction memory every cycle. Each returned instruction is captured, paired with its PC, into a small FIFO. The FIFO feeds decode over a valid/ready handshake, and the block honours branch/jump redirects from execute by flushing all buffered instructions.

## Interface
- RESET_PC, 32'h0000_0000: PC value loaded on reset; bits [1:0] must be zero.
- DEPTH, 2: number of fetch-buffer entries; a power of two, at least 2.

- clk  input  1  single clock; all state changes on its rising edge.
- rst  input  1  reset, asynchronous, active-high.
- inst_addr  output  32  byte address to instruction memory; always equals the current PC.
- inst  input  32  little-endian instruction word returned combinationally for inst_addr in the same cycle.
- redirect_valid  input  1  execute requests a PC change this cycle.
- redirect_pc  input  32  target PC; bits [1:0] are forced to zero.
- out_valid  output  1  FIFO head holds a valid instruction.
- out_ready  input  1  decode accepts the head this cycle.
- out_pc  output  32  PC of the head instruction.
- out_inst  output  32  head instruction word.
- misalign  output  1  one-cycle pulse: the previous cycle's redirect had redirect_pc[1:0] != 0.

## Operation
- State: pc (32 bits), FIFO of DEPTH entries {pc, inst}, rd_ptr, wr_ptr, count (0..DEPTH).
- pop = out_valid & out_ready.
- push = !redirect_valid & (count < DEPTH | pop).
  - On push: write {pc, inst} at wr_ptr, then pc <= pc + 4.
  - PC arithmetic is modulo 2^32: 32'hFFFF_FFFC + 4 = 0.
- Count update:
  - count unchanged on push and pop together.
  - +1 on push only.
  - -1 on pop only.
- Redirect (redirect_valid = 1):
  - pc <= {redirect_pc[31:2], 2'b00}.
  - count, rd_ptr and wr_ptr <= 0. The FIFO is flushed.
  - No push that cycle.
  - A pop occurring in the same cycle still completes; decode owns that instruction. Execute must discard it if it is younger than the redirecting instruction.
- Redirect has priority over every other event.
- misalign <= redirect_valid & (redirect_pc[1:0] != 0). This is a registered pulse; the redirect still proceeds with the aligned PC.
- out_valid = (count != 0). out_pc and out_inst are the entry at rd_ptr.
- While out_valid = 1 and out_ready = 0, out_pc and out_inst must hold stable.
- Reset values:
  - pc = RESET_PC; count, rd_ptr and wr_ptr = 0; all FIFO entries = 0.
  - out_valid = 0, out_pc = 0, out_inst = 0, misalign = 0.
  - inst_addr = RESET_PC.
- Reset asserted mid-operation: all state returns to reset values immediately and asynchronously. Any in-flight instruction is lost.

## Timing
- Fetch latency: an instruction addressed in cycle N appears at out_* in cycle N+1 at the earliest.
- After rst deasserts, the first edge pushes RESET_PC. out_valid = 1 from the following cycle.
- Sustained throughput is 1 instruction/cycle with out_ready held at 1. Full plus pop in the same cycle still pushes, so there is no bubble.
- FIFO full and out_ready = 0: no push. pc and inst_addr hold.
- Redirect in cycle N:
  - inst_addr = target in cycle N+1.
  - out_valid = 0 in cycle N+1.
  - First target instruction valid at out_* in cycle N+2.
- Redirect asserted in consecutive cycles: the last one wins; out_valid stays 0 throughout.
- No combinational path from out_ready or redirect_* to inst_addr. inst_addr is the pc register output.

## Test plan
- Reset and streaming:
  - Stimulus: RESET_PC = 0; memory words 0x00000013, 0x00100093, 0x00200113 at 0, 4, 8; out_ready = 1.
  - Required: out_pc = 0, 4, 8 on consecutive cycles starting one cycle after reset release, with matching out_inst; no gaps.
- Backpressure:
  - Stimulus: out_ready = 0 for 5 cycles, then 1.
  - Required: count saturates at DEPTH = 2; inst_addr holds at 8; out_pc holds at 0 while stalled; the released stream is 0, 4, 8, 12 with no skip or duplicate.
- Redirect with pending entries:
  - Stimulus: FIFO full (pcs 0, 4); redirect_pc = 0x100 with out_ready = 1.
  - Required: entry 0 is consumed; next cycle out_valid = 0 and inst_addr = 0x100; the cycle after, out_pc = 0x100.
- Misaligned redirect:
  - Stimulus: redirect_pc = 0x203.
  - Required: misalign = 1 for exactly one cycle; subsequent out_pc = 0x200.
- Wrap-around:
  - Stimulus: redirect to 0xFFFF_FFF8, out_ready = 1.
  - Required: out_pc sequence is 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
- Mid-stream reset:
  - Stimulus: assert rst between clock edges while the FIFO is full.
  - Required: out_valid = 0, out_pc = 0 and inst_addr = RESET_PC immediately, before the next edge.
